// File: rtl/fpio_fifo_out_arbiter_pkg.sv
// Shared types and constants for the fpio FIFO-out arbiter.
//   arb_state_e      : FSM states (IDLE, ISSUE, WAIT_ACK)
//   tmo_cnt_width()  : width of the ack-timeout counter for a given timeout
//                      value. The result is $clog2(ACK_TIMEOUT+1), never below 1.
package fpio_fifo_out_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_e;

  localparam int ACK_TIMEOUT_DEFAULT = 64;

  function automatic int tmo_cnt_width(input int ack_timeout);
    return (ack_timeout < 1) ? 1 : $clog2(ack_timeout + 1);
  endfunction

  localparam int TMO_CNT_W_DEFAULT = tmo_cnt_width(ACK_TIMEOUT_DEFAULT);

endpackage

// File: rtl/fpio_fifo_out_arbiter_if.sv
// Bundle of the consumer-side and FIFO-side signals of the fpio FIFO-out
// arbiter.
//   consumer side : req (to arbiter), gnt / rd_data (from arbiter)
//   FIFO side     : avail / data / data_ack (to arbiter), data_en (from arbiter)
//   status        : busy, err, err_id (from arbiter)
// Modports:
//   master : the arbiter
//   slave  : the environment, meaning the requesters plus the FIFO
interface fpio_fifo_out_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int FIFO_BITS  = 16,
  parameter int DATA_WIDTH = 8
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         gnt;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic [FIFO_BITS:0]       avail;
  logic                     data_en;
  logic [DATA_WIDTH-1:0]    data;
  logic                     data_ack;
  logic                     busy;
  logic                     err;
  logic [$clog2(N_REQ)-1:0] err_id;

  modport master (
    input  req, avail, data, data_ack,
    output gnt, rd_data, data_en, busy, err, err_id
  );

  modport slave (
    output req, avail, data, data_ack,
    input  gnt, rd_data, data_en, busy, err, err_id
  );
endinterface

// File: rtl/fpio_fifo_out_arbiter_rr.sv
// fpio_rr_arbiter: a purely combinational round-robin pick.
//   i_req    : request vector
//   i_ptr    : index of the last winner; the search starts at i_ptr+1 mod N
//   o_onehot : one-hot winner, all zero when there is no request
//   o_idx    : winner index, 0 when there is no request
//   o_valid  : at least one request is present
module fpio_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_onehot,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_valid
);
  localparam int IW = $clog2(N);

  always_comb begin : rr_pick
    int                w_pos;
    logic [IW-1:0]     w_cand;
    w_pos    = 0;
    w_cand   = '0;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    // Visit the positions ptr+1 .. ptr+N, wrapping at N. The first position
    // with a request wins. The last position visited is ptr itself.
    for (int k = 1; k <= N; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_cand = IW'(w_pos);
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpio_fifo_out_arbiter.sv
// fpio_fifo_out_arbiter: shares one fpio FIFO-out client port among N_REQ
// readers. The arbiter picks a reader by round-robin and allows one read in
// flight at a time. Each completed read returns a single word together with
// a one-cycle gnt pulse to the reader that won.
//   clk, rst : clock, and an asynchronous active-high reset
//   bus      : fpio_fifo_out_arbiter_if.master. It carries req/gnt/rd_data,
//              avail/data_en/data/data_ack and busy/err/err_id.
module fpio_fifo_out_arbiter
  import fpio_fifo_out_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int FIFO_BITS   = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  fpio_fifo_out_arbiter_if.master bus
);
  localparam int                IDX_W     = $clog2(N_REQ);
  localparam int                TMO_W     = tmo_cnt_width(ACK_TIMEOUT);
  localparam bit                TMO_EN    = (ACK_TIMEOUT != 0);
  // The counter holds 0 in the first WAIT_ACK cycle. When it reaches
  // ACK_TIMEOUT-1 with no ack, ACK_TIMEOUT cycles have passed.
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_EN ? TMO_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [IDX_W-1:0]  PTR_RESET = IDX_W'(N_REQ - 1);

  arb_state_e              r_state, w_state_next;
  logic [IDX_W-1:0]        r_ptr, w_ptr_next;
  logic [IDX_W-1:0]        r_cur, w_cur_next;
  logic [N_REQ-1:0]        r_cur_oh, w_cur_oh_next;
  logic [TMO_W-1:0]        r_tmo_cnt, w_tmo_cnt_next;
  logic                    r_data_en, w_data_en_next;
  logic [N_REQ-1:0]        r_gnt, w_gnt_next;
  logic [DATA_WIDTH-1:0]   r_rd_data, w_rd_data_next;
  logic                    r_err, w_err_next;
  logic [IDX_W-1:0]        r_err_id, w_err_id_next;

  logic [FIFO_BITS:0]      w_avail;
  logic                    w_avail_nz;
  logic [N_REQ-1:0]        w_win_oh;
  logic [IDX_W-1:0]        w_win_idx;
  logic                    w_win_valid;

  assign w_avail    = bus.avail;
  assign w_avail_nz = |w_avail;

  fpio_rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_cur_next     = r_cur;
    w_cur_oh_next  = r_cur_oh;
    w_tmo_cnt_next = r_tmo_cnt;
    w_data_en_next = 1'b0;
    w_gnt_next     = '0;
    w_rd_data_next = r_rd_data;
    w_err_next     = 1'b0;
    w_err_id_next  = r_err_id;
    unique case (r_state)
      IDLE: begin
        if (w_win_valid && w_avail_nz) begin
          w_cur_next     = w_win_idx;
          w_cur_oh_next  = w_win_oh;
          w_ptr_next     = w_win_idx;
          w_data_en_next = 1'b1;   // the strobe is high for the ISSUE cycle
          w_state_next   = ISSUE;
        end
      end
      ISSUE: begin
        w_tmo_cnt_next = '0;
        w_state_next   = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An ack in the last allowed cycle takes priority over the timeout.
        if (bus.data_ack) begin
          w_rd_data_next = bus.data;
          w_gnt_next     = r_cur_oh;
          w_state_next   = IDLE;
        end else if (TMO_EN && (r_tmo_cnt == TMO_LAST)) begin
          w_err_next    = 1'b1;
          w_err_id_next = r_cur;
          w_state_next  = IDLE;
        end else if (TMO_EN) begin
          w_tmo_cnt_next = r_tmo_cnt + TMO_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= PTR_RESET;
      r_cur     <= '0;
      r_cur_oh  <= '0;
      r_tmo_cnt <= '0;
      r_data_en <= 1'b0;
      r_gnt     <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
      r_err_id  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_cur     <= w_cur_next;
      r_cur_oh  <= w_cur_oh_next;
      r_tmo_cnt <= w_tmo_cnt_next;
      r_data_en <= w_data_en_next;
      r_gnt     <= w_gnt_next;
      r_rd_data <= w_rd_data_next;
      r_err     <= w_err_next;
      r_err_id  <= w_err_id_next;
    end
  end

  assign bus.data_en = r_data_en;
  assign bus.gnt     = r_gnt;
  assign bus.rd_data = r_rd_data;
  assign bus.busy    = (r_state != IDLE);
  assign bus.err     = r_err;
  assign bus.err_id  = r_err_id;

endmodule

// File: tb/tb_fpio_fifo_out_arbiter.sv
// Self-checking bench for fpio_fifo_out_arbiter. The directed scenarios are
// followed by randomized reads. The expected winner comes from a plain
// round-robin search over the request pattern, and the expected word is the
// data that the bench FIFO returned.
`timescale 1ns/1ps
module tb_fpio_fifo_out_arbiter;
  localparam int N   = 4;
  localparam int FB  = 16;
  localparam int DW  = 8;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fpio_fifo_out_arbiter_if #(.N_REQ(N), .FIFO_BITS(FB), .DATA_WIDTH(DW)) bus ();

  fpio_fifo_out_arbiter #(
    .N_REQ(N), .FIFO_BITS(FB), .DATA_WIDTH(DW), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          model_ptr;
  logic [7:0]  model_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule: the search starts one position after the last winner.
  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Advance to just after the next rising edge. The invariants that must
  // hold in every cycle are checked here.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    check("en_gnt_excl", 32'(bus.data_en & (|bus.gnt)), 32'd0);
  endtask

  // A single read. The call begins in an IDLE cycle and returns in the gnt
  // cycle, or, after a timeout, once the late ack has been checked.
  task automatic read_txn(input logic [3:0] r, input int delay, input logic [7:0] d, input bit drop);
    int w;
    w = rr_pick(r, model_ptr);
    bus.req = r;
    step();
    check("data_en_t1", 32'(bus.data_en), 32'd1);
    check("busy_issue", 32'(bus.busy), 32'd1);
    if (drop) bus.req = r & ~(4'b0001 << w);
    step();
    for (int i = 0; i < delay && i < TMO; i++) begin
      check("wait_en", 32'(bus.data_en), 32'd0);
      check("wait_busy", 32'(bus.busy), 32'd1);
      check("wait_err", 32'(bus.err), 32'd0);
      step();
    end
    if (delay < TMO) begin
      bus.data_ack = 1'b1;
      bus.data     = d;
      step();
      bus.data_ack = 1'b0;
      bus.data     = 8'($urandom);
      check("gnt", 32'(bus.gnt), 32'(4'b0001 << w));
      check("rd_data", 32'(bus.rd_data), 32'(d));
      check("busy_gnt", 32'(bus.busy), 32'd0);
      check("err_gnt", 32'(bus.err), 32'd0);
      model_ptr = w;
      model_rd  = d;
      $display("read req=%b winner=%0d data=%02h ack_delay=%0d drop=%0d", r, w, d, delay, drop);
    end else begin
      check("err", 32'(bus.err), 32'd1);
      check("err_id", 32'(bus.err_id), 32'(w));
      check("gnt_tmo", 32'(bus.gnt), 32'd0);
      check("busy_tmo", 32'(bus.busy), 32'd0);
      model_ptr = w;
      bus.req   = '0;
      step(); step(); step();
      bus.data_ack = 1'b1;
      bus.data     = ~model_rd;
      step();
      bus.data_ack = 1'b0;
      check("late_rd", 32'(bus.rd_data), 32'(model_rd));
      check("late_gnt", 32'(bus.gnt), 32'd0);
      check("late_en", 32'(bus.data_en), 32'd0);
      check("late_err", 32'(bus.err), 32'd0);
      $display("timeout req=%b winner=%0d late ack ignored", r, w);
    end
  endtask

  initial begin
    int last_g;
    logic [3:0] r;
    bus.req      = '0;
    bus.avail    = 17'd5;
    bus.data     = '0;
    bus.data_ack = 1'b0;
    model_ptr    = N - 1;
    model_rd     = '0;

    step(); step();
    check("rst_data_en", 32'(bus.data_en), 32'd0);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_err_id", 32'(bus.err_id), 32'd0);
    rst = 1'b0;
    step();

    // Basic read: req[0], ack one cycle after data_en.
    read_txn(4'b0001, 0, 8'hA5, 1'b0);

    // All requesters held with immediate acks: rotation and a 3-cycle cadence.
    bus.avail = 17'd8;
    last_g = -1;
    for (int k = 0; k < 5; k++) begin
      read_txn(4'b1111, 0, 8'(8'h10 + k), 1'b0);
      if (last_g >= 0) check("rate3", 32'(cyc - last_g), 32'd3);
      last_g = cyc;
    end
    bus.req = '0;
    step();

    // An empty FIFO blocks the issue, however long req is held.
    bus.avail = '0;
    bus.req   = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      step();
      check("avail0_en", 32'(bus.data_en), 32'd0);
      check("avail0_busy", 32'(bus.busy), 32'd0);
    end
    bus.avail = 17'd1;
    read_txn(4'b0010, 1, 8'h5A, 1'b0);
    bus.avail = 17'd9;

    // Timeout on req[2]. The following 0101 pattern must go to req[0].
    read_txn(4'b0100, TMO, 8'h00, 1'b0);
    read_txn(4'b0101, 0, 8'h77, 1'b0);

    // The winner drops its req after data_en, and the read still completes.
    read_txn(4'b0010, 2, 8'h3C, 1'b1);
    bus.req = '0;
    step();

    // A reset arrives in WAIT_ACK together with an ack.
    bus.req = 4'b0010;
    step();
    step();
    rst          = 1'b1;
    bus.data_ack = 1'b1;
    bus.data     = 8'hFF;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_en", 32'(bus.data_en), 32'd0);
    step();
    check("rst_mid_gnt", 32'(bus.gnt), 32'd0);
    check("rst_mid_err", 32'(bus.err), 32'd0);
    check("rst_mid_en", 32'(bus.data_en), 32'd0);
    check("rst_mid_rd", 32'(bus.rd_data), 32'd0);
    rst          = 1'b0;
    bus.data_ack = 1'b0;
    bus.req      = '0;
    model_ptr    = N - 1;
    model_rd     = '0;
    step();
    // The pointer must be back at 3, so req[1] wins over req[3].
    read_txn(4'b1010, 0, 8'hC3, 1'b0);
    read_txn(4'b1000, 1, 8'h96, 1'b0);

    // Randomized reads: random patterns, ack delays that include timeouts,
    // and random drops.
    for (int k = 0; k < 40; k++) begin
      r = 4'($urandom_range(1, 15));
      bus.avail = 17'($urandom_range(1, 31));
      read_txn(r, int'($urandom_range(0, 5)), 8'($urandom), ($urandom_range(0, 3) == 0));
    end
    bus.req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
